// File: rtl/idli_pkg.sv
// idli_pkg: shared types for the idli core as used by the GPIO pin bank.
//   ctr_t      - per-instruction slice counter (0..3)
//   pin_op_t   - pin operation executed by EX
//   gpio_rd_t  - bank read source select (synchronised level or sticky edge flags)
//   io_pins_t  - widest pin vector; narrower banks zero-extend into it
//   ex_debug_t - EX debug bundle, carries the GPIO edge flags
// Helpers: gpio_slice (4b slice of a 16b word), pin_next (new pin level for an op).
package idli_pkg;

  localparam int NUM_GPIO_PINS_MAX = 16;

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    PIN_OP_IN   = 2'd0,
    PIN_OP_OUT  = 2'd1,
    PIN_OP_OUTN = 2'd2,
    PIN_OP_OUTP = 2'd3
  } pin_op_t;

  typedef enum logic {
    GPIO_RD_LEVEL = 1'b0,
    GPIO_RD_EDGE  = 1'b1
  } gpio_rd_t;

  typedef logic [NUM_GPIO_PINS_MAX-1:0] io_pins_t;

  typedef struct packed {
    io_pins_t gpio_pins;
    io_pins_t gpio_edge;
  } ex_debug_t;

  // Select the 4b slice of a 16b word addressed by the slice counter.
  function automatic logic [3:0] gpio_slice(input io_pins_t word, input ctr_t ctr);
    logic [3:0] res;
    case (ctr)
      2'd0:    res = word[3:0];
      2'd1:    res = word[7:4];
      2'd2:    res = word[11:8];
      2'd3:    res = word[15:12];
      default: res = 4'd0;
    endcase
    return res;
  endfunction

  // New level of a targeted output pin; IN leaves it untouched.
  function automatic logic pin_next(input pin_op_t op, input logic cur, input logic pred);
    logic res;
    case (op)
      PIN_OP_OUT:  res = 1'b1;
      PIN_OP_OUTN: res = 1'b0;
      PIN_OP_OUTP: res = pred;
      default:     res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/idli_gpio_sync.sv
// idli_gpio_sync: WIDTH-bit, STAGES-deep flop synchroniser for asynchronous inputs.
// Ports:
//   i_gck   - clock
//   i_rst_n - synchronous active-low reset, clears every stage
//   i_d     - asynchronous input vector
//   o_q     - synchronised vector, STAGES edges behind i_d
module idli_gpio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_gck,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift chain: stage 0 samples the raw input, later stages settle metastability.
  always_ff @(posedge i_gck) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_r[s] <= '0;
      end
    end else begin
      stage_r[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        stage_r[s] <= stage_r[s-1];
      end
    end
  end

  assign o_q = stage_r[STAGES-1];

endmodule

// File: rtl/idli_gpio.sv
// idli_gpio: parametrised GPIO pin bank beside EX.
// Synchronises NUM_PINS inputs, keeps sticky edge flags, drives NUM_PINS
// registered outputs from pin ops, and returns 16b bank reads as four 4b
// slices aligned to the core slice counter.
// Ports:
//   i_gck, i_rst_n     - clock, synchronous active-low reset
//   i_ctr              - slice counter, 0..3 within an instruction
//   i_op_vld/i_op/i_idx/i_pred - pin op, target pin and current P (ops fire at ctr 3)
//   i_rd_vld/i_rd_sel  - bank read valid and source (LEVEL or EDGE)
//   i_pins             - asynchronous external inputs
//   o_pins             - registered external outputs
//   o_in_bit           - synchronised level of pin i_idx (0 when out of range)
//   o_slice            - read data slice i_ctr
//   o_edge_any         - OR of all edge flags
module idli_gpio
  import idli_pkg::*;
#(
  parameter  int NUM_PINS    = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDX_W       = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                i_gck,
  input  logic                i_rst_n,
  input  ctr_t                i_ctr,
  input  logic                i_op_vld,
  input  pin_op_t             i_op,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_pred,
  input  logic                i_rd_vld,
  input  gpio_rd_t            i_rd_sel,
  input  logic [NUM_PINS-1:0] i_pins,
  output logic [NUM_PINS-1:0] o_pins,
  output logic                o_in_bit,
  output logic [3:0]          o_slice,
  output logic                o_edge_any
);

  logic [NUM_PINS-1:0] sync_s;
  logic [NUM_PINS-1:0] prev_r;
  logic [NUM_PINS-1:0] edge_r;
  logic [NUM_PINS-1:0] edge_clr_s;
  logic [NUM_PINS-1:0] edge_nxt_s;
  logic [NUM_PINS-1:0] pins_r;
  logic [NUM_PINS-1:0] pins_nxt_s;
  io_pins_t            src_s;
  io_pins_t            snap_r;
  logic                op_fire_s;
  logic                clr_fire_s;
  logic                snap_fire_s;
  logic                in_bit_s;
  logic [3:0]          slice_s;

  idli_gpio_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_gck   (i_gck),
    .i_rst_n (i_rst_n),
    .i_d     (i_pins),
    .o_q     (sync_s)
  );

  assign op_fire_s   = i_op_vld && (i_ctr == 2'd3);
  assign snap_fire_s = i_rd_vld && (i_ctr == 2'd0);
  assign clr_fire_s  = i_rd_vld && (i_rd_sel == GPIO_RD_EDGE) && (i_ctr == 2'd3);

  // Only flags that were returned by this read are cleared; a new edge in the
  // clear cycle is OR-ed in afterwards, so set wins over clear.
  assign edge_clr_s = clr_fire_s ? snap_r[NUM_PINS-1:0] : '0;
  assign edge_nxt_s = (edge_r & ~edge_clr_s) | (sync_s ^ prev_r);

  // Read source, zero-extended to the 16b bank word.
  always_comb begin
    src_s = '0;
    if (i_rd_sel == GPIO_RD_EDGE) begin
      src_s[NUM_PINS-1:0] = edge_r;
    end else begin
      src_s[NUM_PINS-1:0] = sync_s;
    end
  end

  // Slice 0 is live from the source; later slices come from the snapshot so the word is coherent.
  always_comb begin
    slice_s = 4'd0;
    if (!i_rd_vld) begin
      slice_s = 4'd0;
    end else if (i_ctr == 2'd0) begin
      slice_s = src_s[3:0];
    end else begin
      slice_s = gpio_slice(snap_r, i_ctr);
    end
  end

  // Pin index decode: an index at or beyond NUM_PINS matches no pin, so it
  // reads as 0 and output ops on it have no effect.
  always_comb begin
    in_bit_s   = 1'b0;
    pins_nxt_s = pins_r;
    for (int n = 0; n < NUM_PINS; n++) begin
      in_bit_s = in_bit_s | ((i_idx == IDX_W'(n)) & sync_s[n]);
      if (op_fire_s && (i_idx == IDX_W'(n))) begin
        pins_nxt_s[n] = pin_next(i_op, pins_r[n], i_pred);
      end else begin
        pins_nxt_s[n] = pins_r[n];
      end
    end
  end

  // Bank state: previous sync level, sticky edge flags, read snapshot and output pins.
  always_ff @(posedge i_gck) begin
    if (!i_rst_n) begin
      prev_r <= '0;
      edge_r <= '0;
      snap_r <= '0;
      pins_r <= '0;
    end else begin
      prev_r <= sync_s;
      edge_r <= edge_nxt_s;
      pins_r <= pins_nxt_s;
      if (snap_fire_s) begin
        snap_r <= src_s;
      end
    end
  end

  assign o_pins     = pins_r;
  assign o_in_bit   = in_bit_s;
  assign o_slice    = slice_s;
  assign o_edge_any = |edge_r;

endmodule

// File: tb/tb_idli_gpio.sv
// Self-checking bench for idli_gpio: two banks (5 pins / 3 sync stages and
// 16 pins / 2 sync stages) driven by shared stimulus; a reference model
// predicts each cycle's outputs into queues that a negedge monitor pops.
module tb_idli_gpio;
  import idli_pkg::*;

  localparam int NPA = 5;
  localparam int SSA = 3;
  localparam int NPB = 16;
  localparam int SSB = 2;

  typedef struct {
    bit          ok;
    logic [15:0] pins;
    logic        in_bit;
    logic [3:0]  slice;
    logic        any;
  } exp_t;

  logic        clk = 1'b1;
  logic        rst_n;
  ctr_t        ctr;
  logic        op_vld;
  pin_op_t     op;
  logic [3:0]  idx;
  logic        pred;
  logic        rd_vld;
  gpio_rd_t    rd_sel;
  logic [15:0] pins;

  logic [NPA-1:0] a_pins_o;
  logic           a_in;
  logic [3:0]     a_slice;
  logic           a_any;
  logic [NPB-1:0] b_pins_o;
  logic           b_in;
  logic [3:0]     b_slice;
  logic           b_any;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Reference model state, one entry per bank (0 = A, 1 = B).
  logic [15:0] m_pins [2];
  logic [15:0] m_prev [2];
  logic [15:0] m_edge [2];
  logic [15:0] m_snap [2];
  logic [15:0] m_hist [2][3];
  bit          m_ok   [2] = '{1'b0, 1'b0};
  int          m_np   [2] = '{NPA, NPB};
  int          m_ss   [2] = '{SSA, SSB};

  always #5 clk = ~clk;

  idli_gpio #(.NUM_PINS(NPA), .SYNC_STAGES(SSA)) u_a (
    .i_gck(clk), .i_rst_n(rst_n), .i_ctr(ctr), .i_op_vld(op_vld), .i_op(op),
    .i_idx(idx[2:0]), .i_pred(pred), .i_rd_vld(rd_vld), .i_rd_sel(rd_sel),
    .i_pins(pins[NPA-1:0]), .o_pins(a_pins_o), .o_in_bit(a_in),
    .o_slice(a_slice), .o_edge_any(a_any)
  );

  idli_gpio #(.NUM_PINS(NPB), .SYNC_STAGES(SSB)) u_b (
    .i_gck(clk), .i_rst_n(rst_n), .i_ctr(ctr), .i_op_vld(op_vld), .i_op(op),
    .i_idx(idx), .i_pred(pred), .i_rd_vld(rd_vld), .i_rd_sel(rd_sel),
    .i_pins(pins), .o_pins(b_pins_o), .o_in_bit(b_in),
    .o_slice(b_slice), .o_edge_any(b_any)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int m_idx(input int k);
    return (k == 0) ? int'(idx[2:0]) : int'(idx);
  endfunction

  function automatic logic [15:0] m_mask(input int k);
    return 16'((32'd1 << m_np[k]) - 32'd1);
  endfunction

  // Synchronised level = the pin word sampled m_ss edges ago.
  function automatic logic [15:0] m_sync(input int k);
    return m_hist[k][m_ss[k]-1];
  endfunction

  function automatic logic [15:0] m_src(input int k);
    return (rd_sel == GPIO_RD_EDGE) ? m_edge[k] : m_sync(k);
  endfunction

  function automatic exp_t m_expect(input int k);
    exp_t        e;
    logic [15:0] s;
    logic [15:0] w;
    int          i;
    e.ok   = m_ok[k];
    e.pins = m_pins[k];
    e.any  = |m_edge[k];
    i      = m_idx(k);
    s      = m_sync(k);
    e.in_bit = (i < m_np[k]) ? s[i] : 1'b0;
    if (!rd_vld) begin
      e.slice = 4'd0;
    end else if (ctr == 2'd0) begin
      w = m_src(k);
      e.slice = w[3:0];
    end else begin
      w = m_snap[k] >> (4 * int'(ctr));
      e.slice = w[3:0];
    end
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic m_clock(input int k);
    logic [15:0] s;
    logic [15:0] src;
    logic [15:0] clr;
    int          i;
    if (!rst_n) begin
      m_pins[k] = '0; m_prev[k] = '0; m_edge[k] = '0; m_snap[k] = '0;
      for (int j = 0; j < 3; j++) m_hist[k][j] = '0;
      m_ok[k] = 1'b1;
    end else begin
      s   = m_sync(k);
      src = m_src(k);
      i   = m_idx(k);
      clr = (rd_vld && rd_sel == GPIO_RD_EDGE && ctr == 2'd3) ? m_snap[k] : 16'h0;
      m_edge[k] = (m_edge[k] & ~clr) | (s ^ m_prev[k]);
      m_prev[k] = s;
      for (int j = 2; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = pins & m_mask(k);
      if (rd_vld && ctr == 2'd0) m_snap[k] = src;
      if (op_vld && ctr == 2'd3 && i < m_np[k]) begin
        case (op)
          PIN_OP_OUT:  m_pins[k][i] = 1'b1;
          PIN_OP_OUTN: m_pins[k][i] = 1'b0;
          PIN_OP_OUTP: m_pins[k][i] = pred;
          default:     m_pins[k][i] = m_pins[k][i];
        endcase
      end
    end
  endtask

  // One clock cycle: drive pins, queue predictions, capture bank B's slice.
  task automatic cyc(input logic [15:0] p, output logic [3:0] bs);
    pins = p;
    qa.push_back(m_expect(0));
    qb.push_back(m_expect(1));
    #1 bs = b_slice;
    @(posedge clk);
    #1;
    m_clock(0);
    m_clock(1);
  endtask

  // One 4-cycle instruction; exp_word >= 0 also checks bank B's assembled read word.
  task automatic instr(input logic ov, input pin_op_t o, input logic [3:0] ix, input logic pr,
                       input logic rv, input gpio_rd_t rs, input logic [15:0] p0,
                       input logic [15:0] p1, input int exp_word, input int rst_from);
    logic [15:0] w;
    logic [3:0]  s;
    op_vld = ov; op = o; idx = ix; pred = pr; rd_vld = rv; rd_sel = rs;
    w = '0;
    for (int c = 0; c < 4; c++) begin
      ctr   = ctr_t'(c);
      rst_n = (rst_from >= 0 && c >= rst_from) ? 1'b0 : 1'b1;
      cyc((c == 0) ? p0 : p1, s);
      w[4*c +: 4] = s;
    end
    if (exp_word >= 0) check("b_read_word", w, 16'(exp_word));
  endtask

  task automatic idle(input logic [15:0] p);
    instr(1'b0, PIN_OP_IN, 4'd0, 1'b0, 1'b0, GPIO_RD_LEVEL, p, p, -1, -1);
  endtask

  task automatic op_instr(input pin_op_t o, input logic [3:0] ix, input logic pr, input logic [15:0] p);
    instr(1'b1, o, ix, pr, 1'b0, GPIO_RD_LEVEL, p, p, -1, -1);
  endtask

  task automatic edge_read(input logic [15:0] p0, input logic [15:0] p1, input int exp_word);
    instr(1'b0, PIN_OP_IN, 4'd0, 1'b0, 1'b1, GPIO_RD_EDGE, p0, p1, exp_word, -1);
  endtask

  // Monitor: compare every predicted cycle against both banks mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      if (e.ok) begin
        check("a_pins",  16'(a_pins_o), e.pins);
        check("a_in",    16'(a_in),     16'(e.in_bit));
        check("a_slice", 16'(a_slice),  16'(e.slice));
        check("a_any",   16'(a_any),    16'(e.any));
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      if (e.ok) begin
        check("b_pins",  b_pins_o,      e.pins);
        check("b_in",    16'(b_in),     16'(e.in_bit));
        check("b_slice", 16'(b_slice),  16'(e.slice));
        check("b_any",   16'(b_any),    16'(e.any));
      end
    end
  end

  initial begin
    rst_n = 1'b0; ctr = 2'd0; op_vld = 1'b0; op = PIN_OP_IN; idx = 4'd0;
    pred = 1'b0; rd_vld = 1'b0; rd_sel = GPIO_RD_LEVEL; pins = 16'hF;

    // Reset with inputs high, then a second reset pulse after they propagate.
    instr(1'b0, PIN_OP_IN, 4'd0, 1'b0, 1'b0, GPIO_RD_LEVEL, 16'hF, 16'hF, -1, 0);
    idle(16'hF);
    instr(1'b0, PIN_OP_IN, 4'd0, 1'b0, 1'b1, GPIO_RD_LEVEL, 16'hF, 16'hF, -1, 0);
    check("rst_b_pins", b_pins_o, 16'h0);
    check("rst_b_any", 16'(b_any), 16'h0);

    // Output ops on the cycle after ctr 3, including an out-of-range index on bank A.
    op_instr(PIN_OP_OUT,  4'd2, 1'b0, 16'h0); check("out2",  b_pins_o, 16'h0004);
    op_instr(PIN_OP_OUTN, 4'd2, 1'b0, 16'h0); check("outn2", b_pins_o, 16'h0000);
    op_instr(PIN_OP_OUTP, 4'd1, 1'b1, 16'h0); check("outp1", b_pins_o, 16'h0002);
    op_instr(PIN_OP_OUT,  4'd5, 1'b0, 16'h0);
    check("out5_b", b_pins_o, 16'h0022);
    check("out5_a", 16'(a_pins_o), 16'h0002);
    op_instr(PIN_OP_OUTN, 4'd5, 1'b0, 16'h0); check("outn5", b_pins_o, 16'h0002);

    // Sync latency seen through o_in_bit on pin 3.
    idle(16'h0);
    op_instr(PIN_OP_IN, 4'd3, 1'b0, 16'h8);
    idle(16'h8);

    // Coherent LEVEL read while inputs change after ctr 0.
    idle(16'h1234);
    instr(1'b0, PIN_OP_IN, 4'd0, 1'b0, 1'b1, GPIO_RD_LEVEL, 16'h1234, 16'hFFFF, 32'h1234, -1);

    // EDGE read of pins 0 and 5, then the clear-cycle race on pin 7.
    idle(16'hFFFF);
    edge_read(16'hFFFF, 16'hFFFF, -1);
    idle(16'hFFDE);
    edge_read(16'hFFDE, 16'hFFDE, 32'h0021);
    edge_read(16'hFFDE, 16'hFF5E, 32'h0000);
    check("race_any", 16'(b_any), 16'h1);
    edge_read(16'hFF5E, 16'hFFDE, 32'h0080);
    edge_read(16'hFFDE, 16'hFFDE, 32'h0080);
    check("race_clear_any", 16'(b_any), 16'h0);

    // Concurrent EDGE read and OUTP.
    op_instr(PIN_OP_OUT, 4'd0, 1'b0, 16'hFFDE); check("out0", b_pins_o, 16'h0003);
    idle(16'hFFDF);
    instr(1'b1, PIN_OP_OUTP, 4'd0, 1'b0, 1'b1, GPIO_RD_EDGE, 16'hFFDF, 16'hFFDF, 32'h0001, -1);
    check("conc_pins", b_pins_o, 16'h0002);
    check("conc_any", 16'(b_any), 16'h0);

    // Reset in the middle of an instruction aborts its op.
    instr(1'b1, PIN_OP_OUT, 4'd3, 1'b0, 1'b0, GPIO_RD_LEVEL, 16'hFFDF, 16'hFFDF, -1, 2);
    check("midrst_pins", b_pins_o, 16'h0000);

    // Randomised instructions against the model.
    for (int t = 0; t < 80; t++) begin
      logic [15:0] p0;
      logic [15:0] p1;
      int          rf;
      p0 = 16'($urandom);
      p1 = ($urandom_range(0, 1) == 0) ? p0 : 16'($urandom);
      rf = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      instr(1'($urandom), pin_op_t'($urandom_range(0, 3)), 4'($urandom), 1'($urandom),
            1'($urandom), gpio_rd_t'($urandom_range(0, 1)), p0, p1, -1, rf);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
